seq_detect_param: RTL and testbench

Parametrised Mealy serial-pattern detector, the generalised successor to the fixed 4-bit "1010" detector in the sequential FSM set. It compares a serial bit stream against a runtime-loadable N-bit pattern and supports overlapping and non-overlapping detection, input qualification, and a saturating match counter. Use it wherever a framing, sync-word or command-pattern detector sits on a serial data path.

---
 rtl/seq_detect_param.sv | 80 ++++++++
 tb/tb_seq_detect_param.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Runtime-programmable N-bit serial pattern detector with a Mealy match output,
// selectable overlapping/non-overlapping detection and a saturating match counter.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S0       | no valid history bits (after reset, pattern load or a
//            | non-overlapping match)
//   S1..SN-2 | that many history bits collected, no match possible yet
//   S(N-1)   | history full; every accepted bit is a match candidate
module seq_detect_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1010,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_ovf
);

  localparam int              FW       = $clog2(N);
  localparam logic [FW-1:0]   FILL_MAX = FW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N-1:0]  pat;
  logic [N-2:0]  hist;
  logic [FW-1:0] fill;
  logic [N-1:0]  window;

  // Candidate word: collected history with the incoming bit appended as LSB.
  assign window = {hist, din};

  assign y = reset & din_valid & ~pat_load & (fill == FILL_MAX) & (window == pat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
    end else if (pat_load) begin
      pat  <= pat_in;
      fill <= '0;
    end else if (din_valid) begin
      hist <= window[N-2:0];
      if (y && !overlap)
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q       <= 1'b0;
      match_cnt <= '0;
      cnt_ovf   <= 1'b0;
    end else begin
      y_q <= y;
      // A clear wins over a match in the same cycle; that match is dropped.
      if (cnt_clr) begin
        match_cnt <= '0;
        cnt_ovf   <= 1'b0;
      end else if (y) begin
        if (match_cnt == CNT_MAX)
          cnt_ovf <= 1'b1;
        else
          match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param (N=4, CNT_W=2) with hand-computed
// expectations and immediate assertions at each checkpoint.
module tb_seq_detect_param;

  logic       clk;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;
  logic       y;
  logic       y_q;
  logic [1:0] match_cnt;
  logic       cnt_ovf;

  int checks = 0;
  int errors = 0;

  seq_detect_param #(.N(4), .PATTERN(4'b1010), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .cnt_clr   (cnt_clr),
    .y         (y),
    .y_q       (y_q),
    .match_cnt (match_cnt),
    .cnt_ovf   (cnt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of serial input: y checked before the edge, y_q after it.
  task automatic step(input logic b, input logic v, input logic ey, input string tag,
                      input logic clr = 1'b0);
    @(negedge clk);
    din = b; din_valid = v; cnt_clr = clr;
    #1 chk({tag, "_y"}, {31'd0, y}, {31'd0, ey});
    @(posedge clk);
    #1 chk({tag, "_yq"}, {31'd0, y_q}, {31'd0, ey});
    din_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic load(input logic [3:0] p, input logic b, input logic v);
    @(negedge clk);
    pat_load = 1'b1; pat_in = p; din = b; din_valid = v;
    #1 chk("load_y", {31'd0, y}, 32'd0);
    @(posedge clk);
    #1 pat_load = 1'b0; din_valid = 1'b0;
  endtask

  task automatic clear_cnt();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("clr_cnt", {30'd0, match_cnt}, 32'd0);
    chk("clr_ovf", {31'd0, cnt_ovf}, 32'd0);
  endtask

  initial begin
    logic [5:0] s6;
    logic [5:0] e6;
    logic [7:0] s8;
    logic [7:0] e8;
    int m;

    reset = 1'b0; din = 1'b1; din_valid = 1'b1; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;
    #12;
    chk("rst_y",   {31'd0, y},         32'd0);
    chk("rst_yq",  {31'd0, y_q},       32'd0);
    chk("rst_cnt", {30'd0, match_cnt}, 32'd0);
    chk("rst_ovf", {31'd0, cnt_ovf},   32'd0);
    din_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Overlapping: 1,0,1,0,1,0 matches on bits 4 and 6
    overlap = 1'b1;
    s6 = 6'b101010; e6 = 6'b000101;
    for (int i = 5; i >= 0; i--) step(s6[i], 1'b1, e6[i], "ovl");
    chk("ovl_cnt", {30'd0, match_cnt}, 32'd2);
    clear_cnt();

    // Non-overlapping: 1,0,1,0,1,0,1,0 matches on bits 4 and 8
    load(4'b1010, 1'b0, 1'b0);
    overlap = 1'b0;
    s8 = 8'b10101010; e8 = 8'b00010001;
    for (int i = 7; i >= 2; i--) step(s8[i], 1'b1, e8[i], "novl");
    chk("novl_cnt6", {30'd0, match_cnt}, 32'd1);
    for (int i = 1; i >= 0; i--) step(s8[i], 1'b1, e8[i], "novl");
    chk("novl_cnt8", {30'd0, match_cnt}, 32'd2);
    clear_cnt();

    // Bubbles between accepted bits never break the partial sequence
    overlap = 1'b1;
    load(4'b1010, 1'b0, 1'b0);
    s6[3:0] = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      step(s6[i], 1'b1, (i == 0), "bub");
      if (i != 0)
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, "bub_idle");
    end
    chk("bub_cnt", {30'd0, match_cnt}, 32'd1);
    clear_cnt();

    // Pattern reload discards the same-cycle bit and restarts from S0
    load(4'b1010, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, "rl_pre");
    step(1'b1, 1'b1, 1'b0, "rl_pre");
    step(1'b0, 1'b1, 1'b0, "rl_pre");
    load(4'b1101, 1'b1, 1'b1);
    chk("rl_load_yq", {31'd0, y_q}, 32'd0);
    s6[3:0] = 4'b1101;
    for (int i = 3; i >= 0; i--) step(s6[i], 1'b1, (i == 0), "rl");
    clear_cnt();

    // Saturation with a 2-bit counter: all-ones pattern, overlapping
    load(4'b1111, 1'b0, 1'b0);
    overlap = 1'b1;
    m = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, (i >= 4), "sat");
      if (i >= 4) m++;
      chk("sat_cnt", {30'd0, match_cnt}, (m > 3) ? 32'd3 : 32'(m));
      chk("sat_ovf", {31'd0, cnt_ovf},   (m > 3) ? 32'd1 : 32'd0);
    end
    step(1'b1, 1'b1, 1'b1, "sat_clr", 1'b1);
    chk("sat_clr_cnt", {30'd0, match_cnt}, 32'd0);
    chk("sat_clr_ovf", {31'd0, cnt_ovf},   32'd0);

    // Asynchronous reset mid-stream restores the default pattern and S0
    step(1'b1, 1'b1, 1'b1, "mid_pre");
    chk("mid_pre_cnt", {30'd0, match_cnt}, 32'd1);
    #2;
    din = 1'b1; din_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("mid_rst_y",   {31'd0, y},         32'd0);
    chk("mid_rst_yq",  {31'd0, y_q},       32'd0);
    chk("mid_rst_cnt", {30'd0, match_cnt}, 32'd0);
    chk("mid_rst_ovf", {31'd0, cnt_ovf},   32'd0);
    @(negedge clk);
    din_valid = 1'b0;
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0, "post_rst");
    s6[3:0] = 4'b1010;
    for (int i = 3; i >= 0; i--) step(s6[i], 1'b1, (i == 0), "post_rst");
    chk("post_rst_cnt", {30'd0, match_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
